// File: rtl/memory_access.sv
// MIPS MEM stage: byte-lane data RAM with LB/LBU/LH/LHU/LW/SB/SH/SW, misalignment
// detection and the MEM/WB pipeline register.
`default_nettype none

module memory_access #(
  parameter int NB_REG  = 32,
  parameter int NB_MEM  = 5,
  parameter int NB_WB   = 8,
  parameter int NB_ADDR = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_REG-1:0]  i_alu,
  input  logic [NB_REG-1:0]  i_b,
  input  logic [NB_MEM-1:0]  i_mem,
  input  logic [NB_WB-1:0]   i_wb,
  input  logic [NB_REG-1:0]  i_pc,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_REG-1:0]  o_data,
  output logic [NB_REG-1:0]  o_alu,
  output logic [NB_WB-1:0]   o_wb,
  output logic [NB_REG-1:0]  o_pc,
  output logic               o_misaligned,
  output logic [NB_REG-1:0]  o_dbg_data
);

  localparam int LANES = NB_REG / 8;
  localparam int DEPTH = 1 << NB_ADDR;

  logic               rd, wr, uns;
  logic [1:0]         sz, off;
  logic [NB_ADDR-1:0] idx;
  logic               mis, bad, accept, do_write, do_load;
  logic [LANES-1:0]   be;
  logic [NB_REG-1:0]  wdata;
  logic               unused_alu;

  logic [NB_REG-1:0]  ram [DEPTH];
  logic [NB_REG-1:0]  rd_word;
  logic               load_q, uns_q;
  logic [1:0]         sz_q, off_q;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;

  assign rd  = i_mem[4];
  assign wr  = i_mem[3];
  assign sz  = i_mem[2:1];
  assign uns = i_mem[0];
  assign idx = i_alu[NB_ADDR+1:2];
  assign off = i_alu[1:0];
  assign unused_alu = &{1'b0, i_alu[NB_REG-1:NB_ADDR+2]};

  always_comb begin
    mis   = 1'b0;
    be    = '1;
    wdata = i_b;
    case (sz)
      2'b00: begin
        be    = LANES'(1) << off;
        wdata = {LANES{i_b[7:0]}};
      end
      2'b01: begin
        mis   = off[0];
        be    = LANES'(3) << off;
        wdata = {(LANES/2){i_b[15:0]}};
      end
      default: mis = (off != 2'b00);  // 10 behaves as word
    endcase
  end

  // A store wins over a load when both control bits are set.
  assign bad      = (rd | wr) & mis;
  assign accept   = i_valid & ~i_reset;
  assign do_write = accept & wr & ~mis;
  assign do_load  = accept & rd & ~wr & ~mis;

  always_ff @(posedge i_clock) begin
    if (do_write) begin
      for (int k = 0; k < LANES; k++) begin
        if (be[k]) ram[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    if (do_load) rd_word <= ram[idx];
  end

  // Debug port reads every cycle; non-blocking semantics give read-first behaviour.
  always_ff @(posedge i_clock) begin
    if (i_reset) o_dbg_data <= '0;
    else         o_dbg_data <= ram[i_dbg_addr];
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      load_q       <= 1'b0;
      uns_q        <= 1'b0;
      sz_q         <= 2'b00;
      off_q        <= 2'b00;
      o_alu        <= '0;
      o_wb         <= '0;
      o_pc         <= '0;
      o_misaligned <= 1'b0;
    end else if (i_valid) begin
      load_q       <= do_load;
      uns_q        <= uns;
      sz_q         <= sz;
      off_q        <= off;
      o_alu        <= i_alu;
      o_wb         <= i_wb;
      o_pc         <= i_pc;
      o_misaligned <= bad;
    end
  end

  assign byte_sel = rd_word[{off_q, 3'b000} +: 8];
  assign half_sel = rd_word[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    o_data = '0;
    if (load_q) begin
      case (sz_q)
        2'b00:   o_data = {{(NB_REG-8){~uns_q & byte_sel[7]}}, byte_sel};
        2'b01:   o_data = {{(NB_REG-16){~uns_q & half_sel[15]}}, half_sel};
        default: o_data = rd_word;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access.
`default_nettype none

module tb_memory_access;

  logic        clock = 1'b0;
  logic        reset, valid;
  logic [31:0] alu, b, pc;
  logic [4:0]  mem;
  logic [7:0]  wb;
  logic [9:0]  dbg_addr;
  logic [31:0] data, alu_q, pc_q, dbg_data;
  logic [7:0]  wb_q;
  logic        misaligned;

  int vectors = 0;
  int miscompares = 0;

  // {rd, wr, sz, uns}
  localparam logic [4:0] OP_ALU = 5'b00000, OP_SW = 5'b01110, OP_SH = 5'b01010,
                         OP_SB = 5'b01000, OP_LW = 5'b10110, OP_LH = 5'b10010,
                         OP_LHU = 5'b10011, OP_LB = 5'b10000, OP_LBU = 5'b10001,
                         OP_LW10 = 5'b10100, OP_RW = 5'b11110;

  memory_access dut (
    .i_clock(clock), .i_reset(reset), .i_valid(valid), .i_alu(alu), .i_b(b),
    .i_mem(mem), .i_wb(wb), .i_pc(pc), .i_dbg_addr(dbg_addr),
    .o_data(data), .o_alu(alu_q), .o_wb(wb_q), .o_pc(pc_q),
    .o_misaligned(misaligned), .o_dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [4:0] m, input logic [31:0] a,
                      input logic [31:0] bv, input logic [7:0] w, input logic [31:0] p);
    valid = v; mem = m; alu = a; b = bv; wb = w; pc = p;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; mem = '0; alu = '0; b = '0; wb = '0; pc = '0;
    dbg_addr = 10'd4;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rst_data", data, 32'h0);
    check("rst_alu", alu_q, 32'h0);
    check("rst_wb", {24'h0, wb_q}, 32'h0);
    check("rst_pc", pc_q, 32'h0);
    check("rst_mis", {31'h0, misaligned}, 32'h0);
    check("rst_dbg", dbg_data, 32'h0);
    reset = 1'b0;

    // Word store then load
    step(1, OP_SW, 32'h10, 32'hDEADBEEF, 8'h11, 32'h100);
    check("sw_alu", alu_q, 32'h10);
    check("sw_wb", {24'h0, wb_q}, 32'h11);
    check("sw_pc", pc_q, 32'h100);
    check("sw_data", data, 32'h0);
    step(1, OP_LW, 32'h10, 32'h0, 8'h12, 32'h104);
    check("lw_data", data, 32'hDEADBEEF);
    check("lw_dbg", dbg_data, 32'hDEADBEEF);

    // Sub-word loads
    step(1, OP_LB, 32'h13, 32'h0, 8'h13, 32'h108);
    check("lb", data, 32'hFFFFFFDE);
    step(1, OP_LBU, 32'h13, 32'h0, 8'h14, 32'h10C);
    check("lbu", data, 32'h000000DE);
    step(1, OP_LH, 32'h10, 32'h0, 8'h15, 32'h110);
    check("lh", data, 32'hFFFFBEEF);
    step(1, OP_LHU, 32'h12, 32'h0, 8'h16, 32'h114);
    check("lhu", data, 32'h0000DEAD);

    // Sub-word stores; debug port is read-first on the store edge
    step(1, OP_SB, 32'h11, 32'h00000055, 8'h17, 32'h118);
    check("sb_dbg_old", dbg_data, 32'hDEADBEEF);
    step(1, OP_LW, 32'h10, 32'h0, 8'h18, 32'h11C);
    check("sb_lw", data, 32'hDEAD55EF);
    check("sb_dbg_new", dbg_data, 32'hDEAD55EF);
    step(1, OP_SH, 32'h12, 32'hAAAA1234, 8'h19, 32'h120);
    step(1, OP_LW, 32'h10, 32'h0, 8'h1A, 32'h124);
    check("sh_lw", data, 32'h123455EF);

    // Misaligned store and load
    step(1, OP_SW, 32'h12, 32'hCAFEF00D, 8'h1B, 32'h128);
    check("sw_mis_flag", {31'h0, misaligned}, 32'h1);
    check("sw_mis_data", data, 32'h0);
    check("sw_mis_alu", alu_q, 32'h12);
    step(1, OP_LW, 32'h10, 32'h0, 8'h1C, 32'h12C);
    check("mis_nowrite", data, 32'h123455EF);
    check("mis_dbg", dbg_data, 32'h123455EF);
    check("lw_mis_clr", {31'h0, misaligned}, 32'h0);
    step(1, OP_LH, 32'h11, 32'h0, 8'h1D, 32'h130);
    check("lh_mis_flag", {31'h0, misaligned}, 32'h1);
    check("lh_mis_data", data, 32'h0);

    // rd and wr together act as a store
    step(1, OP_LW, 32'h10, 32'h0, 8'h1E, 32'h134);
    step(1, OP_RW, 32'h14, 32'h0BADF00D, 8'h1F, 32'h138);
    check("rw_data", data, 32'h0);
    check("rw_mis", {31'h0, misaligned}, 32'h0);
    step(1, OP_LW, 32'h14, 32'h0, 8'h20, 32'h13C);
    check("rw_lw", data, 32'h0BADF00D);

    // Stalled stage: no write, outputs hold, debug still live
    dbg_addr = 10'd5;
    step(0, OP_SW, 32'h10, 32'hFFFFFFFF, 8'h21, 32'h140);
    check("hold_data", data, 32'h0BADF00D);
    check("hold_alu", alu_q, 32'h14);
    check("hold_wb", {24'h0, wb_q}, 32'h20);
    check("hold_pc", pc_q, 32'h13C);
    check("hold_dbg", dbg_data, 32'h0BADF00D);
    dbg_addr = 10'd4;
    step(1, OP_LW, 32'h10, 32'h0, 8'h22, 32'h144);
    check("hold_nowrite", data, 32'h123455EF);

    // Reset during a store
    reset = 1'b1;
    step(1, OP_SW, 32'h10, 32'hFFFFFFFF, 8'h23, 32'h148);
    check("rst2_data", data, 32'h0);
    check("rst2_alu", alu_q, 32'h0);
    check("rst2_wb", {24'h0, wb_q}, 32'h0);
    check("rst2_pc", pc_q, 32'h0);
    check("rst2_dbg", dbg_data, 32'h0);
    reset = 1'b0;
    step(1, OP_LW, 32'h10, 32'h0, 8'h24, 32'h14C);
    check("rst2_nowrite", data, 32'h123455EF);

    // Full-rate mix, including sz=10 as word
    step(1, OP_SW, 32'h20, 32'h11223344, 8'hA1, 32'h200);
    check("b2b0_alu", alu_q, 32'h20);
    check("b2b0_wb", {24'h0, wb_q}, 32'hA1);
    check("b2b0_pc", pc_q, 32'h200);
    step(1, OP_LW, 32'h20, 32'h0, 8'hA2, 32'h204);
    check("b2b1_data", data, 32'h11223344);
    check("b2b1_wb", {24'h0, wb_q}, 32'hA2);
    check("b2b1_pc", pc_q, 32'h204);
    step(1, OP_ALU, 32'h12345677, 32'h0, 8'hA3, 32'h208);
    check("b2b2_alu", alu_q, 32'h12345677);
    check("b2b2_data", data, 32'h0);
    check("b2b2_mis", {31'h0, misaligned}, 32'h0);
    check("b2b2_pc", pc_q, 32'h208);
    step(1, OP_LW10, 32'h20, 32'h0, 8'hA4, 32'h20C);
    check("sz10_data", data, 32'h11223344);
    step(1, OP_LW10, 32'h21, 32'h0, 8'hA5, 32'h210);
    check("sz10_mis", {31'h0, misaligned}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
